// File: rtl/direccionamiento.sv
// Address-generation unit for the 8-bit datapath: decodes a 5-bit addressing
// command into a registered data-memory address, write data and RW strobe.
// Optional macro DIRECC_VALID_EN adds a registered o_Valid access pulse.
module direccionamiento #(
  parameter logic [7:0] INDEX_RST = 8'h00,
  parameter logic [7:0] PTR_RST   = 8'h00
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic [4:0]  i_Control_Direc,
  input  logic [15:0] i_DireccionDato,
  output logic [7:0]  o_Direccion_Datos,
  output logic [7:0]  o_Salida_Datos,
  output logic        o_RW
`ifdef DIRECC_VALID_EN
  ,
  output logic        o_Valid
`endif
);

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [2:0] {
    MODE_NOP      = 3'b000,
    MODE_DIRECT   = 3'b001,
    MODE_INDEXED  = 3'b010,
    MODE_LD_INDEX = 3'b011,
    MODE_INDIRECT = 3'b100,
    MODE_POST_INC = 3'b101,
    MODE_LD_PTR   = 3'b110,
    MODE_PRE_DEC  = 3'b111
  } mode_e;

  mode_e             mode;
  logic              rw;
  logic              en;
  logic [BYTE_W-1:0] a_byte;
  logic [BYTE_W-1:0] d_byte;

  logic [BYTE_W-1:0] index_q;
  logic [BYTE_W-1:0] ptr_q;

  logic [BYTE_W-1:0] addr_d;
  logic [BYTE_W-1:0] data_d;
  logic              rw_d;
  logic [BYTE_W-1:0] index_d;
  logic [BYTE_W-1:0] ptr_d;
  logic [BYTE_W-1:0] ptr_dec;
  logic              access;

  assign mode    = mode_e'(i_Control_Direc[4:2]);
  assign rw      = i_Control_Direc[1];
  assign en      = i_Control_Direc[0];
  assign a_byte  = i_DireccionDato[15:8];
  assign d_byte  = i_DireccionDato[7:0];
  assign ptr_dec = BYTE_W'(ptr_q - BYTE_W'(1));

  // Next-state decode; anything not touched by the command holds.
  always_comb begin
    addr_d  = o_Direccion_Datos;
    data_d  = o_Salida_Datos;
    rw_d    = 1'b0;
    index_d = index_q;
    ptr_d   = ptr_q;
    access  = 1'b0;
    if (en) begin
      case (mode)
        MODE_NOP: ;
        MODE_DIRECT: begin
          access = 1'b1;
          addr_d = a_byte;
        end
        MODE_INDEXED: begin
          access = 1'b1;
          addr_d = BYTE_W'(a_byte + index_q);
        end
        MODE_LD_INDEX: index_d = d_byte;
        MODE_INDIRECT: begin
          access = 1'b1;
          addr_d = ptr_q;
        end
        MODE_POST_INC: begin
          access = 1'b1;
          addr_d = ptr_q;
          ptr_d  = BYTE_W'(ptr_q + BYTE_W'(1));
        end
        MODE_LD_PTR: ptr_d = a_byte;
        MODE_PRE_DEC: begin
          access = 1'b1;
          addr_d = ptr_dec;
          ptr_d  = ptr_dec;
        end
      endcase
    end
    // Memory accesses always refresh the data bus; reads park it at zero.
    if (access) begin
      data_d = rw ? d_byte : '0;
      rw_d   = rw;
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      o_Direccion_Datos <= '0;
      o_Salida_Datos    <= '0;
      o_RW              <= 1'b0;
      index_q           <= INDEX_RST;
      ptr_q             <= PTR_RST;
    end else begin
      o_Direccion_Datos <= addr_d;
      o_Salida_Datos    <= data_d;
      o_RW              <= rw_d;
      index_q           <= index_d;
      ptr_q             <= ptr_d;
    end
  end

`ifdef DIRECC_VALID_EN
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) o_Valid <= 1'b0;
    else       o_Valid <= access;
  end
`endif

endmodule

// File: tb/tb_direccionamiento.sv
// Scoreboard bench for direccionamiento: a reference model pushes expected
// outputs per command; they are popped and compared after the sampling edge.
module tb_direccionamiento;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    logic       rw;
    logic       valid;
  } exp_t;

  logic        i_Clk = 1'b0;
  logic        i_Rst;
  logic [4:0]  i_Control_Direc;
  logic [15:0] i_DireccionDato;
  logic [7:0]  o_Direccion_Datos;
  logic [7:0]  o_Salida_Datos;
  logic        o_RW;
`ifdef DIRECC_VALID_EN
  logic        o_Valid;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  exp_t sb[$];
  logic [7:0] m_idx, m_ptr, m_addr, m_data;

  direccionamiento #(.INDEX_RST(8'h00), .PTR_RST(8'h00)) dut (
    .i_Clk             (i_Clk),
    .i_Rst             (i_Rst),
    .i_Control_Direc   (i_Control_Direc),
    .i_DireccionDato   (i_DireccionDato),
    .o_Direccion_Datos (o_Direccion_Datos),
    .o_Salida_Datos    (o_Salida_Datos),
    .o_RW              (o_RW)
`ifdef DIRECC_VALID_EN
    ,
    .o_Valid           (o_Valid)
`endif
  );

  always #5 i_Clk = ~i_Clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_idx  = 8'h00;
    m_ptr  = 8'h00;
    m_addr = 8'h00;
    m_data = 8'h00;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_addr"}, 16'(o_Direccion_Datos), 16'h0);
    check({tag, "_data"}, 16'(o_Salida_Datos), 16'h0);
    check({tag, "_rw"}, 16'(o_RW), 16'h0);
`ifdef DIRECC_VALID_EN
    check({tag, "_valid"}, 16'(o_Valid), 16'h0);
`endif
  endtask

  // Reference model: one command in, one expected output record out.
  task automatic model_step(input logic [4:0] c, input logic [15:0] dd);
    exp_t e;
    logic [7:0] a, d;
    logic mem;
    a   = dd[15:8];
    d   = dd[7:0];
    mem = 1'b0;
    if (c[0]) begin
      case (c[4:2])
        3'b001: begin m_addr = a; mem = 1'b1; end
        3'b010: begin m_addr = a + m_idx; mem = 1'b1; end
        3'b011: m_idx = d;
        3'b100: begin m_addr = m_ptr; mem = 1'b1; end
        3'b101: begin m_addr = m_ptr; m_ptr = m_ptr + 8'd1; mem = 1'b1; end
        3'b110: m_ptr = a;
        3'b111: begin m_ptr = m_ptr - 8'd1; m_addr = m_ptr; mem = 1'b1; end
        default: ;
      endcase
    end
    if (mem) m_data = c[1] ? d : 8'h00;
    e.addr  = m_addr;
    e.data  = m_data;
    e.rw    = mem & c[1];
    e.valid = mem;
    sb.push_back(e);
  endtask

  task automatic send(input string tag, input logic [4:0] c, input logic [15:0] dd);
    exp_t e;
    @(negedge i_Clk);
    i_Control_Direc = c;
    i_DireccionDato = dd;
    model_step(c, dd);
    @(posedge i_Clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 16'h1, 16'h0);
    end else begin
      e = sb.pop_front();
      check({tag, "_addr"}, 16'(o_Direccion_Datos), 16'(e.addr));
      check({tag, "_data"}, 16'(o_Salida_Datos), 16'(e.data));
      check({tag, "_rw"}, 16'(o_RW), 16'(e.rw));
`ifdef DIRECC_VALID_EN
      check({tag, "_valid"}, 16'(o_Valid), 16'(e.valid));
`endif
    end
  endtask

  task automatic pulse_reset(input string tag);
    @(negedge i_Clk);
    i_Control_Direc = 5'($urandom);
    i_DireccionDato = 16'($urandom);
    i_Rst = 1'b1;
    #1;
    check_reset_outputs(tag);
    model_reset();
    @(negedge i_Clk);
    i_Rst = 1'b0;
  endtask

  initial begin
    i_Rst           = 1'b1;
    i_Control_Direc = 5'($urandom);
    i_DireccionDato = 16'($urandom);
    #1;
    check_reset_outputs("rst_init");
    repeat (3) begin
      @(negedge i_Clk);
      i_Control_Direc = 5'($urandom);
      i_DireccionDato = 16'($urandom);
    end
    #1;
    check_reset_outputs("rst_held");
    model_reset();
    @(negedge i_Clk);
    i_Rst = 1'b0;

    send("indirect_after_rst", 5'b10001, 16'h1234);
    send("direct_rd", 5'b00101, 16'h03F8);
    send("direct_wr", 5'b00111, 16'hAA55);
    send("hold_en0", 5'b10110, 16'h9999);
    send("nop", 5'b00001, 16'h7777);
    send("ld_index", 5'b01101, 16'h0055);
    send("indexed_wrap", 5'b01011, 16'hF07D);
    send("ld_ptr", 5'b11001, 16'hFF00);
    send("post_inc_a", 5'b10101, 16'h0000);
    pulse_reset("rst_mid");
    send("post_inc_after_rst", 5'b10101, 16'h0000);

    send("ld_ptr_ff", 5'b11001, 16'hFF00);
    send("post_inc_ff", 5'b10101, 16'h0000);
    send("post_inc_wrap", 5'b10101, 16'h0000);
    send("pre_dec_1", 5'b11101, 16'h0000);
    send("pre_dec_wrap", 5'b11111, 16'h00C3);
    send("ld_index_rw1", 5'b01111, 16'h11A0);
    send("ld_ptr_rw1", 5'b11011, 16'h8022);
    send("indexed_rd", 5'b01001, 16'h1000);
    send("indirect_wr", 5'b10011, 16'h005A);

    for (int i = 0; i < 60; i++) begin
      send("rand", 5'($urandom), 16'($urandom));
    end

    check("sb_drained", 16'(sb.size()), 16'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
